// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter and its refresh timer.
package vram_arb_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;

  // Cycles spent waiting for mem_busy to rise before assuming the command
  // was absorbed without a busy period.
  localparam int WAIT_HI_TIMEOUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_VDP,
    SRC_HI,
    SRC_REF
  } src_t;

  // Fixed priority: urgent refresh, then VDP, then super-res, then a
  // normal refresh. When urgency is disabled the timer never raises it.
  function automatic src_t pick_source(input logic urgent, input logic vdp,
                                       input logic hi, input logic ref_pend);
    src_t src;
    src = SRC_NONE;
    if (urgent) begin
      src = SRC_REF;
    end else if (vdp) begin
      src = SRC_VDP;
    end else if (hi) begin
      src = SRC_HI;
    end else if (ref_pend) begin
      src = SRC_REF;
    end
    return src;
  endfunction

endpackage

// File: rtl/vram_refresh_timer.sv
// Refresh token generator: an 11-bit interval down-counter hands out one
// token per REFRESH_INTERVAL cycles into a 3-bit saturating token count.
// Optional macro VRAM_ARB_URGENT_REFRESH_EN enables the urgent flag; without
// it the flag stays low and refresh only runs when nothing else is pending.
module vram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 1600,
  parameter int REFRESH_URGENT   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_i,
  output logic pending_o,
  output logic urgent_o
);

  localparam logic [10:0] RELOAD     = 11'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]  TOKENS_MAX = 3'd7;

  logic [10:0] interval_q, interval_d;
  logic [2:0]  tokens_q, tokens_d;
  logic        tick;

  // Next-state for the interval counter and the token count.
  always_comb begin
    tick       = (interval_q == 11'd0);
    interval_d = tick ? RELOAD : (interval_q - 11'd1);
    tokens_d   = tokens_q;
    if (tick && !grant_i) begin
      if (tokens_q != TOKENS_MAX) begin
        tokens_d = tokens_q + 3'd1;
      end
    end else if (!tick && grant_i) begin
      if (tokens_q != 3'd0) begin
        tokens_d = tokens_q - 3'd1;
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interval_q <= RELOAD;
      tokens_q   <= 3'd0;
    end else begin
      interval_q <= interval_d;
      tokens_q   <= tokens_d;
    end
  end

  assign pending_o = (tokens_q != 3'd0);

`ifdef VRAM_ARB_URGENT_REFRESH_EN
  assign urgent_o = (tokens_q >= 3'(REFRESH_URGENT));
`else
  assign urgent_o = 1'b0;
`endif

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one SDRAM controller between VDP accesses,
// super-res fetches and periodic refresh. All controller-facing outputs are
// registered. Optional macro VRAM_ARB_URGENT_REFRESH_EN lets a backlog of
// refresh tokens pre-empt the VDP.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1600,
  parameter int REFRESH_URGENT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enabled,
  input  logic              vdp_req,
  input  logic              vdp_we,
  input  logic [ADDR_W-1:0] vdp_addr,
  input  logic [DATA_W-1:0] vdp_wdata,
  input  logic [1:0]        vdp_wdm,
  output logic              vdp_ack,
  output logic              vdp_rvalid,
  input  logic              hi_req,
  input  logic [ADDR_W-1:0] hi_addr,
  output logic              hi_ack,
  output logic              hi_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic [1:0]        mem_wdm,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              state_q;
  src_t                src_q;
  src_t                winner;
  logic                we_q;
  logic [1:0]          wait_cnt_q;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;
  logic [1:0]          mem_wdm_q;
  logic                mem_read_q, mem_write_q, mem_refresh_q;
  logic                vdp_ack_q, hi_ack_q, vdp_rvalid_q, hi_rvalid_q;
  logic                ref_pending, ref_urgent;
  logic                can_grant, ref_grant;

  vram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .REFRESH_URGENT   (REFRESH_URGENT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .grant_i   (ref_grant),
    .pending_o (ref_pending),
    .urgent_o  (ref_urgent)
  );

  // Pick the winner and decide whether a grant happens this cycle.
  always_comb begin
    winner    = pick_source(ref_urgent, vdp_req, hi_req, ref_pending);
    can_grant = (state_q == ST_IDLE) && mem_enabled && !mem_busy &&
                (winner != SRC_NONE);
    ref_grant = can_grant && (winner == SRC_REF);
  end

  // Arbiter FSM with registered strobes, acks, read data and command fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_NONE;
      we_q          <= 1'b0;
      wait_cnt_q    <= 2'd0;
      dout_q        <= '0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_wdm_q     <= 2'b00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      vdp_ack_q     <= 1'b0;
      hi_ack_q      <= 1'b0;
      vdp_rvalid_q  <= 1'b0;
      hi_rvalid_q   <= 1'b0;
    end else begin
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      vdp_ack_q     <= 1'b0;
      hi_ack_q      <= 1'b0;
      vdp_rvalid_q  <= 1'b0;
      hi_rvalid_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (can_grant) begin
            state_q    <= ST_CMD;
            src_q      <= winner;
            wait_cnt_q <= 2'd0;
            case (winner)
              SRC_VDP: begin
                mem_read_q  <= !vdp_we;
                mem_write_q <= vdp_we;
                we_q        <= vdp_we;
                vdp_ack_q   <= 1'b1;
                mem_addr_q  <= vdp_addr;
                mem_din_q   <= vdp_wdata;
                mem_wdm_q   <= vdp_wdm;
              end
              SRC_HI: begin
                mem_read_q <= 1'b1;
                we_q       <= 1'b0;
                hi_ack_q   <= 1'b1;
                mem_addr_q <= hi_addr;
                mem_din_q  <= '0;
                mem_wdm_q  <= 2'b00;
              end
              SRC_REF: begin
                mem_refresh_q <= 1'b1;
                we_q          <= 1'b0;
                mem_addr_q    <= '0;
                mem_din_q     <= '0;
                mem_wdm_q     <= 2'b00;
              end
              default: begin
                we_q <= 1'b0;
              end
            endcase
          end
        end
        ST_CMD: begin
          state_q    <= ST_WAIT_HI;
          wait_cnt_q <= 2'd0;
        end
        ST_WAIT_HI: begin
          if (mem_busy || (wait_cnt_q == 2'(WAIT_HI_TIMEOUT - 1))) begin
            state_q <= ST_WAIT_LO;
          end else begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!mem_busy) begin
            state_q <= ST_RESP;
            dout_q  <= mem_dout;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          if (src_q == SRC_VDP && !we_q) begin
            rdata_q      <= dout_q;
            vdp_rvalid_q <= 1'b1;
          end else if (src_q == SRC_HI) begin
            rdata_q     <= dout_q;
            hi_rvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign vdp_ack     = vdp_ack_q;
  assign hi_ack      = hi_ack_q;
  assign vdp_rvalid  = vdp_rvalid_q;
  assign hi_rvalid   = hi_rvalid_q;
  assign rdata       = rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_refresh = mem_refresh_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_wdm     = mem_wdm_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: main instance with default refresh
// interval, second instance with REFRESH_INTERVAL=16 for refresh priority.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        mem_enabled, vdp_req, vdp_we, hi_req, mem_busy;
  logic [22:0] vdp_addr, hi_addr, mem_addr;
  logic [31:0] vdp_wdata, mem_dout, mem_din, rdata;
  logic [1:0]  vdp_wdm, mem_wdm;
  logic        vdp_ack, vdp_rvalid, hi_ack, hi_rvalid;
  logic        mem_read, mem_write, mem_refresh;

  vram_arbiter dut (
    .clk(clk), .reset(reset), .mem_enabled(mem_enabled),
    .vdp_req(vdp_req), .vdp_we(vdp_we), .vdp_addr(vdp_addr),
    .vdp_wdata(vdp_wdata), .vdp_wdm(vdp_wdm), .vdp_ack(vdp_ack),
    .vdp_rvalid(vdp_rvalid), .hi_req(hi_req), .hi_addr(hi_addr),
    .hi_ack(hi_ack), .hi_rvalid(hi_rvalid), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_wdm(mem_wdm),
    .mem_busy(mem_busy), .mem_dout(mem_dout)
  );

  // Second instance: refresh interval 16, VDP reads only.
  logic        r_rst = 1'b1, r_en = 1'b0, r_vdp_req = 1'b0, r_busy = 1'b0;
  int          r_bcnt = 0;
  logic        r_vdp_ack, r_vdp_rvalid, r_hi_ack, r_hi_rvalid;
  logic        r_read, r_write, r_refresh;
  logic [22:0] r_addr;
  logic [31:0] r_din, r_rdata;
  logic [1:0]  r_wdm;

  vram_arbiter #(.REFRESH_INTERVAL(16), .REFRESH_URGENT(4)) dut_r (
    .clk(clk), .reset(r_rst), .mem_enabled(r_en),
    .vdp_req(r_vdp_req), .vdp_we(1'b0), .vdp_addr(23'h0),
    .vdp_wdata(32'h0), .vdp_wdm(2'b00), .vdp_ack(r_vdp_ack),
    .vdp_rvalid(r_vdp_rvalid), .hi_req(1'b0), .hi_addr(23'h0),
    .hi_ack(r_hi_ack), .hi_rvalid(r_hi_rvalid), .rdata(r_rdata),
    .mem_read(r_read), .mem_write(r_write), .mem_refresh(r_refresh),
    .mem_addr(r_addr), .mem_din(r_din), .mem_wdm(r_wdm),
    .mem_busy(r_busy), .mem_dout(32'h0)
  );

  // Controller models: busy rises the cycle after a strobe, for busy_len cycles.
  int busy_len = 2;
  int bcnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      mem_busy <= 1'b0;
      bcnt     <= 0;
    end else if ((mem_read | mem_write | mem_refresh) && busy_len > 0) begin
      mem_busy <= 1'b1;
      bcnt     <= busy_len;
    end else if (bcnt > 0) begin
      if (bcnt == 1) mem_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  always @(posedge clk) begin
    if (r_rst) begin
      r_busy <= 1'b0;
      r_bcnt <= 0;
    end else if (r_read | r_write | r_refresh) begin
      r_busy <= 1'b1;
      r_bcnt <= 2;
    end else if (r_bcnt > 0) begin
      if (r_bcnt == 1) r_busy <= 1'b0;
      r_bcnt <= r_bcnt - 1;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Per-window observations, cycle numbers relative to the start edge.
  int cyc, n_cmd, n_rd, n_wr, n_rf, n_vack, n_hack, n_vrv, n_hrv;
  int vack_c, vack2_c, hack_c, vrv_c, hrv_c;
  logic [31:0] vrv_data, hrv_data, din1;
  logic [22:0] addr1, addr2;
  logic [1:0]  wdm1;

  task automatic start();
    @(posedge clk);
    #1;
    cyc = 0; n_cmd = 0; n_rd = 0; n_wr = 0; n_rf = 0;
    n_vack = 0; n_hack = 0; n_vrv = 0; n_hrv = 0;
    vack_c = -1; vack2_c = -1; hack_c = -1; vrv_c = -1; hrv_c = -1;
    vrv_data = '0; hrv_data = '0; din1 = '0; addr1 = '0; addr2 = '0; wdm1 = '0;
  endtask

  task automatic run(input int ncyc, input bit rereq, input logic [22:0] rereq_addr);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mem_read | mem_write | mem_refresh) begin
        n_cmd++;
        if (n_cmd == 1) begin
          addr1 = mem_addr; din1 = mem_din; wdm1 = mem_wdm;
        end else if (n_cmd == 2) begin
          addr2 = mem_addr;
        end
      end
      n_rd += int'(mem_read);
      n_wr += int'(mem_write);
      n_rf += int'(mem_refresh);
      if (vdp_ack) begin
        n_vack++;
        if (vack_c < 0) vack_c = cyc;
        else if (vack2_c < 0) vack2_c = cyc;
        vdp_req = 1'b0;
      end
      if (hi_ack) begin
        n_hack++;
        if (hack_c < 0) hack_c = cyc;
        hi_req = 1'b0;
      end
      if (vdp_rvalid) begin
        n_vrv++;
        if (vrv_c < 0) begin
          vrv_c = cyc; vrv_data = rdata;
          if (rereq) begin
            vdp_req = 1'b1; vdp_addr = rereq_addr;
          end
        end
      end
      if (hi_rvalid) begin
        n_hrv++;
        if (hrv_c < 0) begin
          hrv_c = cyc; hrv_data = rdata;
        end
      end
    end
  endtask

  int rc, nref, first_ref;

  initial begin
    reset = 1'b1; mem_enabled = 1'b1; vdp_req = 1'b0; vdp_we = 1'b0;
    vdp_addr = '0; vdp_wdata = '0; vdp_wdm = 2'b00; hi_req = 1'b0;
    hi_addr = '0; mem_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {29'b0, mem_read, mem_write, mem_refresh}, 32'h0);
    check("rst_acks", {28'b0, vdp_ack, hi_ack, vdp_rvalid, hi_rvalid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", {9'b0, mem_addr}, 32'h0);
    check("rst_din", mem_din, 32'h0);
    check("rst_wdm", {30'b0, mem_wdm}, 32'h0);
    reset = 1'b0;

    start();
    run(5, 1'b0, 23'h0);
    check("idle_no_cmd", n_cmd, 0);
    $display("txn idle: commands=%0d", n_cmd);

    // VDP read, 6-cycle busy period.
    busy_len = 6; mem_dout = 32'hDEADBEEF;
    start();
    vdp_we = 1'b0; vdp_addr = 23'h000100; vdp_req = 1'b1;
    run(20, 1'b0, 23'h0);
    check("rd_count", n_rd, 1);
    check("rd_other_cmds", n_wr + n_rf, 0);
    check("rd_addr", {9'b0, addr1}, 32'h100);
    check("rd_ack_cyc", vack_c, 1);
    check("rd_rvalid_cyc", vrv_c, 10);
    check("rd_rdata", vrv_data, 32'hDEADBEEF);
    check("rd_rvalid_n", n_vrv, 1);
    check("rd_hi_rvalid_n", n_hrv, 0);
    $display("txn vdp_read: ack@%0d rvalid@%0d rdata=0x%08h", vack_c, vrv_c, vrv_data);

    // VDP masked write.
    busy_len = 2;
    start();
    vdp_we = 1'b1; vdp_wdm = 2'b10; vdp_wdata = 32'h000000AB;
    vdp_addr = 23'h0055AA; vdp_req = 1'b1;
    run(15, 1'b0, 23'h0);
    check("wr_count", n_wr, 1);
    check("wr_no_read", n_rd, 0);
    check("wr_din", din1, 32'hAB);
    check("wr_wdm", {30'b0, wdm1}, 32'h2);
    check("wr_addr", {9'b0, addr1}, 32'h55AA);
    check("wr_ack_cyc", vack_c, 1);
    check("wr_no_rvalid", n_vrv, 0);
    $display("txn vdp_write: ack@%0d din=0x%08h wdm=%b", vack_c, din1, wdm1);
    vdp_we = 1'b0; vdp_wdm = 2'b00;

    // Simultaneous VDP and super-res requests.
    busy_len = 2; mem_dout = 32'h0BADF00D;
    start();
    vdp_addr = 23'h000200; hi_addr = 23'h7ABCDE;
    vdp_req = 1'b1; hi_req = 1'b1;
    run(20, 1'b0, 23'h0);
    check("both_vack_cyc", vack_c, 1);
    check("both_hack_cyc", hack_c, 7);
    check("both_reads", n_rd, 2);
    check("both_hi_addr", {9'b0, addr2}, 32'h7ABCDE);
    check("both_vrv_cyc", vrv_c, 6);
    check("both_hrv_cyc", hrv_c, 12);
    check("both_hrv_data", hrv_data, 32'h0BADF00D);
    check("both_ack_n", n_vack + n_hack, 2);
    $display("txn vdp_hi: vack@%0d hack@%0d hrvalid@%0d", vack_c, hack_c, hrv_c);

    // Busy never rises: timeout path, then an immediate new request.
    busy_len = 0; mem_dout = 32'h12345678;
    start();
    vdp_addr = 23'h000300; vdp_req = 1'b1;
    run(20, 1'b1, 23'h000301);
    check("to_rvalid_cyc", vrv_c, 8);
    check("to_rdata", vrv_data, 32'h12345678);
    check("to_reack_cyc", vack2_c, 9);
    check("to_reads", n_rd, 2);
    check("to_rvalid_n", n_vrv, 2);
    $display("txn timeout: rvalid@%0d reack@%0d", vrv_c, vack2_c);

    // mem_enabled falls during a read; hi request must wait.
    busy_len = 3; mem_dout = 32'h55AA55AA;
    start();
    vdp_addr = 23'h000400; vdp_req = 1'b1;
    run(2, 1'b0, 23'h0);
    mem_enabled = 1'b0; hi_addr = 23'h001234; hi_req = 1'b1;
    run(15, 1'b0, 23'h0);
    check("dis_rvalid_cyc", vrv_c, 7);
    check("dis_no_hi_ack", n_hack, 0);
    check("dis_reads", n_rd, 1);
    mem_enabled = 1'b1;
    run(12, 1'b0, 23'h0);
    check("dis_hack_cyc", hack_c, 18);
    $display("txn disable: vrvalid@%0d hack@%0d", vrv_c, hack_c);

    // Reset while waiting for mem_busy to fall.
    busy_len = 6; vdp_wdata = 32'hCAFEF00D; vdp_wdm = 2'b01;
    start();
    vdp_addr = 23'h000500; vdp_req = 1'b1;
    run(5, 1'b0, 23'h0);
    check("mrst_din_loaded", din1, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    check("mrst_rdata", rdata, 32'h0);
    check("mrst_addr", {9'b0, mem_addr}, 32'h0);
    check("mrst_din", mem_din, 32'h0);
    check("mrst_wdm", {30'b0, mem_wdm}, 32'h0);
    check("mrst_pulses", {25'b0, mem_read, mem_write, mem_refresh,
                          vdp_ack, hi_ack, vdp_rvalid, hi_rvalid}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start();
    run(20, 1'b0, 23'h0);
    check("mrst_no_rvalid", n_vrv + n_hrv, 0);
    check("mrst_no_cmd", n_cmd, 0);
    $display("txn reset_mid: rvalids_after=%0d", n_vrv + n_hrv);

    // Refresh priority against a continuously requesting VDP.
    @(posedge clk);
    #1;
    r_vdp_req = 1'b1; r_en = 1'b1; r_rst = 1'b0;
    rc = 0; nref = 0; first_ref = -1;
    repeat (200) begin
      @(posedge clk);
      #1;
      rc++;
      if (r_refresh) begin
        nref++;
        if (first_ref < 0) first_ref = rc;
      end
    end
`ifdef VRAM_ARB_URGENT_REFRESH_EN
    check("ref_not_early", 32'(first_ref >= 65), 32'h1);
    check("ref_granted_soon", 32'(first_ref >= 0 && first_ref <= 75), 32'h1);
    check("ref_repeats", 32'(nref >= 5), 32'h1);
    check("ref_tokens_low", 32'(dut_r.u_timer.tokens_q <= 3'd4), 32'h1);
`else
    check("ref_starved", nref, 0);
    check("ref_tokens_sat", {29'b0, dut_r.u_timer.tokens_q}, 32'h7);
`endif
    $display("txn refresh_busy_vdp: refreshes=%0d first@%0d", nref, first_ref);
    r_vdp_req = 1'b0;
    nref = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (r_refresh) nref++;
    end
`ifdef VRAM_ARB_URGENT_REFRESH_EN
    check("ref_drain", 32'(nref >= 3), 32'h1);
`else
    check("ref_drain", 32'(nref >= 7), 32'h1);
`endif
    $display("txn refresh_idle_vdp: refreshes=%0d", nref);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
